write_back: RTL and testbench

- Final pipeline stage. Directly downstream of the execute stage; consumes the execute-to-write interface.
- Retires register writes and flag updates into the architectural register file.
- Issues data-memory stores through a waitrequest-style bus.
- Raises a PC redirect (flush) when an instruction targets the PC register.
- Back-pressures execute through the interface `hold` while a store is outstanding.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/i_execute_to_write.sv | 27 ++
 rtl/write_back_store_port.sv | 130 +++++++++++++
 rtl/write_back.sv | 115 +++++++++++
 tb/tb_write_back.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: register file, register indices and flag bit positions.
package cpu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NUM_REGS  = 16;
    localparam int unsigned REG_IDX_W = 4;

    typedef logic [XLEN-1:0]      regval_t;
    typedef logic [REG_IDX_W-1:0] regidx_t;
    typedef regval_t [NUM_REGS-1:0] regfile_t;

    localparam regidx_t REG_ZERO  = 4'd0;
    localparam regidx_t REG_FLAGS = 4'd14;
    localparam regidx_t REG_PC    = 4'd15;

    localparam int unsigned FLAGS_LSB     = 27;
    localparam int unsigned FLAG_CARRY    = 30;
    localparam int unsigned FLAG_NEGATIVE = 29;
    localparam int unsigned FLAG_OVERFLOW = 28;
    localparam int unsigned FLAG_ZERO     = FLAGS_LSB;

    typedef enum logic [0:0] {
        SP_IDLE  = 1'b0,
        SP_STORE = 1'b1
    } store_state_e;

    // Overlay {carry, negative, overflow, zero} onto a Flags value, keeping other bits.
    function automatic regval_t merge_flags(input regval_t old_flags, input logic [3:0] f);
        regval_t r;
        r                = old_flags;
        r[FLAG_CARRY]    = f[3];
        r[FLAG_NEGATIVE] = f[2];
        r[FLAG_OVERFLOW] = f[1];
        r[FLAG_ZERO]     = f[0];
        return r;
    endfunction

endpackage

// File: rtl/i_execute_to_write.sv
// Execute-to-write pipeline interface; the write stage drives only hold.
interface i_execute_to_write;
    import cpu_pkg::*;

    logic      is_valid;
    regval_t   pc;
    regidx_t   destination_register;
    logic      is_writing_memory;
    logic [3:0] flags;
    regval_t   destination_value;
    regval_t   adjustment_value;
    logic      has_flushed;
    logic      hold;

    modport write_in (
        input  is_valid, pc, destination_register, is_writing_memory, flags,
               destination_value, adjustment_value, has_flushed,
        output hold
    );

    modport execute_out (
        output is_valid, pc, destination_register, is_writing_memory, flags,
               destination_value, adjustment_value, has_flushed,
        input  hold
    );

endinterface

// File: rtl/write_back_store_port.sv
// Store bus port: IDLE/STORE FSM with registered bus outputs.
// WRITE_BACK_STORE_BUFFER_EN adds a one-entry buffer behind the bus port.
module store_port
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              accept_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  regval_t           data_i,
    input  logic              mem_waitrequest_i,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output regval_t           mem_data_o,
    output logic              busy_o,
    output logic              full_o
);

    store_state_e      state_q, state_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    regval_t           data_q, data_d;

`ifdef WRITE_BACK_STORE_BUFFER_EN
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    regval_t           buf_data_q, buf_data_d;

    // Buffer register; a parked store is issued as soon as the bus accepts the current one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= 32'd0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign full_o = buf_valid_q;
`else
    assign full_o = (state_q == SP_STORE);
`endif

    // Bus state register; reset abandons any in-flight store.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SP_IDLE;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            mem_write_q <= mem_write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    // Next-state logic: address and data stay frozen until the bus accepts.
    always_comb begin
        state_d     = state_q;
        mem_write_d = mem_write_q;
        addr_d      = addr_q;
        data_d      = data_q;
`ifdef WRITE_BACK_STORE_BUFFER_EN
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
`endif
        case (state_q)
            SP_IDLE: begin
                if (accept_i) begin
                    state_d     = SP_STORE;
                    mem_write_d = 1'b1;
                    addr_d      = addr_i;
                    data_d      = data_i;
                end else begin
                    state_d     = SP_IDLE;
                end
            end
            SP_STORE: begin
`ifdef WRITE_BACK_STORE_BUFFER_EN
                if (!mem_waitrequest_i) begin
                    if (buf_valid_q) begin
                        addr_d      = buf_addr_q;
                        data_d      = buf_data_q;
                        buf_valid_d = 1'b0;
                    end else if (accept_i) begin
                        addr_d = addr_i;
                        data_d = data_i;
                    end else begin
                        state_d     = SP_IDLE;
                        mem_write_d = 1'b0;
                    end
                end else begin
                    if (accept_i) begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = addr_i;
                        buf_data_d  = data_i;
                    end else begin
                        buf_valid_d = buf_valid_q;
                    end
                end
`else
                if (!mem_waitrequest_i) begin
                    state_d     = SP_IDLE;
                    mem_write_d = 1'b0;
                end else begin
                    state_d     = SP_STORE;
                end
`endif
            end
            default: begin
                state_d     = SP_IDLE;
                mem_write_d = 1'b0;
            end
        endcase
    end

    assign busy_o        = (state_q == SP_STORE);
    assign mem_write_o   = mem_write_q;
    assign mem_address_o = addr_q;
    assign mem_data_o    = data_q;

endmodule

// File: rtl/write_back.sv
// Write-back stage: retires register/flag writes, raises PC redirects, issues stores.
// WRITE_BACK_STORE_BUFFER_EN lets stores and retires proceed while a store drains.
module write_back
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    i_execute_to_write.write_in ini,
    output regfile_t          registers,
    output logic              redirect,
    output regval_t           redirect_pc,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output regval_t           mem_data,
    input  logic              mem_waitrequest
);

    regfile_t registers_q, registers_d;
    logic     redirect_q, redirect_d;
    regval_t  redirect_pc_q, redirect_pc_d;
    logic     drop_q, drop_d;

    logic     busy_s, full_s, hold_s, take_s, retire_s, store_s;
    regval_t  store_sum_s;
    logic     unused_pc_s;

    assign unused_pc_s = ^ini.pc;

`ifdef WRITE_BACK_STORE_BUFFER_EN
    assign hold_s = ini.is_valid & ini.is_writing_memory & full_s;
    logic unused_busy_s;
    assign unused_busy_s = busy_s;
`else
    assign hold_s = ini.is_valid & busy_s;
    logic unused_full_s;
    assign unused_full_s = full_s;
`endif

    // Flushed-path instructions (has_flushed = 0) are swallowed while dropping.
    assign take_s      = ini.is_valid & ~hold_s;
    assign retire_s    = take_s & ~(drop_q & ~ini.has_flushed);
    assign store_s     = retire_s & ini.is_writing_memory;
    assign store_sum_s = registers_q[ini.destination_register] + ini.adjustment_value;
    assign ini.hold    = hold_s;

    store_port #(.ADDR_W(ADDR_W)) u_store_port (
        .clock             (clock),
        .reset_n           (reset_n),
        .accept_i          (store_s),
        .addr_i            (store_sum_s[ADDR_W-1:0]),
        .data_i            (ini.destination_value),
        .mem_waitrequest_i (mem_waitrequest),
        .mem_write_o       (mem_write),
        .mem_address_o     (mem_address),
        .mem_data_o        (mem_data),
        .busy_o            (busy_s),
        .full_o            (full_s)
    );

    // Architectural state and redirect outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            registers_q   <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            drop_q        <= 1'b0;
        end else begin
            registers_q   <= registers_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            drop_q        <= drop_d;
        end
    end

    // Retire decode: R0 takes only the flag update, PC redirects, Flags is written whole.
    always_comb begin
        registers_d   = registers_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        drop_d        = drop_q;
        if (take_s && drop_q && ini.has_flushed) begin
            drop_d = 1'b0;
        end else begin
            drop_d = drop_q;
        end
        if (retire_s && !ini.is_writing_memory) begin
            case (ini.destination_register)
                REG_ZERO: begin
                    registers_d[REG_FLAGS] = merge_flags(registers_q[REG_FLAGS], ini.flags);
                end
                REG_PC: begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = ini.destination_value;
                    drop_d        = 1'b1;
                end
                REG_FLAGS: begin
                    registers_d[REG_FLAGS] = ini.destination_value;
                end
                default: begin
                    registers_d[ini.destination_register] = ini.destination_value;
                    registers_d[REG_FLAGS] = merge_flags(registers_q[REG_FLAGS], ini.flags);
                end
            endcase
        end else begin
            registers_d = registers_q;
        end
    end

    assign registers   = registers_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: vector table, directed corner sequences, random vs. model.
module tb_write_back;
    import cpu_pkg::*;

    localparam int unsigned ADDR_W = 32;

    logic              clock;
    logic              reset_n;
    regfile_t          registers;
    logic              redirect;
    regval_t           redirect_pc;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    regval_t           mem_data;
    logic              mem_waitrequest;

    i_execute_to_write ex();

    write_back #(.ADDR_W(ADDR_W)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .ini             (ex),
        .registers       (registers),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_data        (mem_data),
        .mem_waitrequest (mem_waitrequest)
    );

    int total  = 0;
    int passed = 0;

    logic [31:0] m_regs [16];
    logic        m_drop;
    logic [31:0] m_rpc;
    logic [63:0] exp_q [$];

    typedef struct {
        logic [3:0]  dest;
        logic [31:0] val;
        logic [3:0]  fl;
        logic [3:0]  exp_idx;
        logic [31:0] exp_val;
        logic [31:0] exp_flags;
    } vec_t;
    vec_t vecs [6];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_regs();
        int bad;
        bad = -1;
        for (int k = 0; k < 16; k++)
            if (registers[k] !== m_regs[k] && bad < 0) bad = k;
        total++;
        if (bad < 0) passed++;
        else $display("FAIL regfile: R%0d got %h expected %h", bad, registers[bad], m_regs[bad]);
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic [31:0] val,
                         input logic [3:0] f, input logic m, input logic [31:0] adj, input logic hf);
        ex.is_valid             = v;
        ex.pc                   = 32'h0000_0000;
        ex.destination_register = d;
        ex.destination_value    = val;
        ex.flags                = f;
        ex.is_writing_memory    = m;
        ex.adjustment_value     = adj;
        ex.has_flushed          = hf;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);
        mem_waitrequest = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    // One random cycle: drive, sample before the edge, then update the model and compare.
    task automatic rand_cycle(input logic idle);
        logic v, m, hf, h, acc, exp_redir;
        logic [3:0] d, f;
        logic [31:0] val, adj, a, dd;
        logic [63:0] e;
        v   = idle ? 1'b0 : ($urandom_range(0, 9) < 8);
        m   = ($urandom_range(0, 4) == 0);
        d   = 4'($urandom_range(0, 15));
        val = $urandom;
        adj = $urandom_range(0, 255);
        f   = 4'($urandom_range(0, 15));
        hf  = ($urandom_range(0, 2) == 0);
        drive(v, d, val, f, m, adj, hf);
        mem_waitrequest = idle ? 1'b0 : 1'($urandom_range(0, 1));
        #3;
        h   = ex.hold;
        acc = mem_write && !mem_waitrequest;
        a   = mem_address;
        dd  = mem_data;
        if (h) chk("hold_without_store", {31'd0, mem_write}, 32'd1);
        tick();
        exp_redir = 1'b0;
        if (v && !h && (!m_drop || hf)) begin
            m_drop = 1'b0;
            if (m) exp_q.push_back({m_regs[d] + adj, val});
            else if (d == 4'd15) begin exp_redir = 1'b1; m_rpc = val; m_drop = 1'b1; end
            else if (d == 4'd14) m_regs[14] = val;
            else begin
                if (d != 4'd0) m_regs[d] = val;
                m_regs[14][30:27] = f;
            end
        end
        chk_regs();
        chk("rand_redirect", {31'd0, redirect}, {31'd0, exp_redir});
        chk("rand_redirect_pc", redirect_pc, m_rpc);
        if (acc) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL bus_unexpected: got store %h/%h expected none", a, dd);
            end else begin
                e = exp_q.pop_front();
                chk("bus_addr", a, e[63:32]);
                chk("bus_data", dd, e[31:0]);
            end
        end
    endtask

    initial begin
        vecs[0] = '{4'd5,  32'h0000_1234, 4'b0001, 4'd5,  32'h0000_1234, 32'h0800_0000};
        vecs[1] = '{4'd0,  32'hFFFF_FFFF, 4'b1010, 4'd0,  32'h0000_0000, 32'h5000_0000};
        vecs[2] = '{4'd14, 32'h8000_0001, 4'b1111, 4'd14, 32'h8000_0001, 32'h8000_0001};
        vecs[3] = '{4'd7,  32'hA5A5_A5A5, 4'b0110, 4'd7,  32'hA5A5_A5A5, 32'hB000_0001};
        vecs[4] = '{4'd13, 32'h0000_0042, 4'b1111, 4'd13, 32'h0000_0042, 32'hF800_0001};
        vecs[5] = '{4'd1,  32'hFFFF_FFFF, 4'b0000, 4'd1,  32'hFFFF_FFFF, 32'h8000_0001};

        // Reset state, with a valid store presented.
        reset_n = 1'b0;
        drive(1'b1, 4'd2, 32'h1111_1111, 4'd0, 1'b1, 32'd0, 1'b0);
        mem_waitrequest = 1'b1;
        repeat (2) tick();
        chk("reset_regs_zero", {31'd0, |registers}, 32'd0);
        chk("reset_redirect", {31'd0, redirect}, 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        chk("reset_mem_write", {31'd0, mem_write}, 32'd0);
        chk("reset_mem_address", mem_address, 32'd0);
        chk("reset_mem_data", mem_data, 32'd0);
        chk("reset_hold", {31'd0, ex.hold}, 32'd0);
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);
        mem_waitrequest = 1'b0;
        reset_n = 1'b1;
        tick();

        // Register/flag retire table.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].dest, vecs[i].val, vecs[i].fl, 1'b0, 32'd0, 1'b0);
            tick();
            chk("vec_reg", registers[vecs[i].exp_idx], vecs[i].exp_val);
            chk("vec_flags", registers[14], vecs[i].exp_flags);
            chk("vec_r0", registers[0], 32'd0);
        end

        // PC write, two flushed-path instructions, then the first has_flushed one.
        drive(1'b1, 4'd15, 32'h0000_0400, 4'd0, 1'b0, 32'd0, 1'b0);
        tick();
        chk("redir_pulse", {31'd0, redirect}, 32'd1);
        chk("redir_pc", redirect_pc, 32'h0000_0400);
        drive(1'b1, 4'd3, 32'h0000_0055, 4'b1111, 1'b0, 32'd0, 1'b0);
        tick();
        chk("redir_once", {31'd0, redirect}, 32'd0);
        drive(1'b1, 4'd6, 32'h0000_0066, 4'b1111, 1'b1, 32'd0, 1'b0);
        tick();
        chk("drop_r3", registers[3], 32'd0);
        chk("drop_flags", registers[14], 32'h8000_0001);
        chk("drop_store", {31'd0, mem_write}, 32'd0);
        drive(1'b1, 4'd3, 32'h0000_0007, 4'b0000, 1'b0, 32'd0, 1'b1);
        tick();
        chk("flushed_r3", registers[3], 32'd7);
        drive(1'b1, 4'd8, 32'h0000_0009, 4'b0000, 1'b0, 32'd0, 1'b0);
        tick();
        chk("drop_cleared_r8", registers[8], 32'd9);

        // Store stalled three cycles by waitrequest.
        drive(1'b1, 4'd2, 32'h0000_0100, 4'b0000, 1'b0, 32'd0, 1'b0);
        tick();
        drive(1'b1, 4'd2, 32'hDEAD_BEEF, 4'b0000, 1'b1, 32'd8, 1'b0);
        mem_waitrequest = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("st_mem_write", {31'd0, mem_write}, 32'd1);
            chk("st_addr", mem_address, 32'h0000_0108);
            chk("st_data", mem_data, 32'hDEAD_BEEF);
            drive(1'b1, 4'd9, 32'h0000_0099, 4'b0000, 1'b0, 32'd0, 1'b0);
            mem_waitrequest = (k < 3);
            #1;
`ifdef WRITE_BACK_STORE_BUFFER_EN
            chk("st_hold", {31'd0, ex.hold}, 32'd0);
`else
            chk("st_hold", {31'd0, ex.hold}, 32'd1);
`endif
            tick();
        end
        chk("st_release", {31'd0, mem_write}, 32'd0);
        chk("st_hold_idle", {31'd0, ex.hold}, 32'd0);
        tick();
        chk("st_r9", registers[9], 32'h0000_0099);

        // Reset in the middle of a store.
        drive(1'b1, 4'd2, 32'h1234_5678, 4'b0000, 1'b1, 32'd0, 1'b0);
        mem_waitrequest = 1'b1;
        tick();
        chk("rst_pre_mem_write", {31'd0, mem_write}, 32'd1);
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mem_write_async", {31'd0, mem_write}, 32'd0);
        chk("rst_regs_async", {31'd0, |registers}, 32'd0);
        tick();
        reset_n = 1'b1;
        mem_waitrequest = 1'b0;
        drive(1'b1, 4'd0, 32'h0000_CAFE, 4'd0, 1'b1, 32'h0000_0020, 1'b0);
        tick();
        chk("rst_next_store_we", {31'd0, mem_write}, 32'd1);
        chk("rst_next_store_addr", mem_address, 32'h0000_0020);
        chk("rst_next_store_data", mem_data, 32'h0000_CAFE);
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);
        tick();
        chk("rst_next_store_done", {31'd0, mem_write}, 32'd0);

`ifdef WRITE_BACK_STORE_BUFFER_EN
        // Back-to-back stores plus a retire under stall.
        do_reset();
        mem_waitrequest = 1'b1;
        drive(1'b1, 4'd0, 32'hAAAA_AAAA, 4'd0, 1'b1, 32'h0000_0040, 1'b0);
        tick();
        drive(1'b1, 4'd0, 32'hBBBB_BBBB, 4'd0, 1'b1, 32'h0000_0044, 1'b0);
        #1;
        chk("buf_no_hold_b", {31'd0, ex.hold}, 32'd0);
        tick();
        drive(1'b1, 4'd4, 32'h0000_0001, 4'd0, 1'b0, 32'd0, 1'b0);
        #1;
        chk("buf_no_hold_r4", {31'd0, ex.hold}, 32'd0);
        tick();
        chk("buf_r4", registers[4], 32'd1);
        chk("buf_a_addr", mem_address, 32'h0000_0040);
        chk("buf_a_data", mem_data, 32'hAAAA_AAAA);
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);
        mem_waitrequest = 1'b0;
        tick();
        chk("buf_b_we", {31'd0, mem_write}, 32'd1);
        chk("buf_b_addr", mem_address, 32'h0000_0044);
        chk("buf_b_data", mem_data, 32'hBBBB_BBBB);
        tick();
        chk("buf_drained", {31'd0, mem_write}, 32'd0);
`endif

        // Randomized run against the reference model.
        do_reset();
        for (int k = 0; k < 16; k++) m_regs[k] = 32'd0;
        m_drop = 1'b0;
        m_rpc  = 32'd0;
        for (int i = 0; i < 600; i++) rand_cycle(1'b0);
        for (int i = 0; i < 6; i++) rand_cycle(1'b1);
        chk("bus_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
